gzip_stream_arbiter: RTL and testbench

Shares one streaming gzip compression datapath between N_STREAMS independent AXI4-Stream requesters. Input side: packet-granular round-robin arbiter that forwards whole packets (up to and including tlast) into the compressor. Output side: a grant-order ID FIFO routes each compressed packet back to the requester that issued it. Sits between the per-stream input interfaces and the compressor wrapper.

---
 rtl/gzip_stream_arbiter_pkg.sv | 10 +
 rtl/gzip_stream_arbiter_if.sv | 15 +
 rtl/gzip_id_fifo.sv | 53 +++++
 rtl/gzip_stream_arbiter.sv | 118 +++++++++++
 tb/tb_gzip_stream_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gzip_stream_arbiter_pkg.sv
// Shared types and defaults for the gzip stream arbiter: stream IDs,
// arbiter state encoding and default sizing constants.
package gzip_stream_arbiter_pkg;
  localparam int N_STREAMS_DFLT     = 4;
  localparam int ID_FIFO_DEPTH_DFLT = 16;

  typedef logic [$clog2(N_STREAMS_DFLT)-1:0] stream_id_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/gzip_stream_arbiter_if.sv
// AXI4-Stream bundle carrying LANES parallel streams; lane i occupies slice i
// of tdata/tkeep and bit i of tlast/tvalid/tready.
interface gzip_stream_arbiter_if #(
  parameter int LANES     = 1,
  parameter int DATA_BITS = 512
);
  logic [LANES*DATA_BITS-1:0]   tdata;
  logic [LANES*DATA_BITS/8-1:0] tkeep;
  logic [LANES-1:0]             tlast;
  logic [LANES-1:0]             tvalid;
  logic [LANES-1:0]             tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/gzip_id_fifo.sv
// Synchronous FIFO of stream IDs recording grant order; push and pop may
// occur in the same cycle with occupancy unchanged.
module gzip_id_fifo
  import gzip_stream_arbiter_pkg::*;
#(
  parameter int DEPTH = ID_FIFO_DEPTH_DFLT,
  parameter int W     = $bits(stream_id_t)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gzip_stream_arbiter.sv
// Packet-granular round-robin sharing of one gzip compressor between
// N_STREAMS requesters; returned packets are routed back in grant order.
module gzip_stream_arbiter
  import gzip_stream_arbiter_pkg::*;
#(
  parameter int N_STREAMS     = N_STREAMS_DFLT,
  parameter int DATA_BITS     = 512,
  parameter int ID_FIFO_DEPTH = ID_FIFO_DEPTH_DFLT
) (
  input  logic                           clk,
  input  logic                           rst,
  gzip_stream_arbiter_if.slave           s,
  gzip_stream_arbiter_if.master          c_in,
  gzip_stream_arbiter_if.slave           c_out,
  gzip_stream_arbiter_if.master          m,
  output logic [$clog2(ID_FIFO_DEPTH):0] inflight
);
  localparam int IW = $clog2(N_STREAMS);
  localparam int KB = DATA_BITS / 8;

  typedef logic [IW-1:0] sid_t;

  arb_state_t state, state_nxt;
  sid_t       grant, grant_nxt;
  sid_t       rr, rr_nxt;
  sid_t       head;
  logic       push, pop, full, empty, found;
  int         idx;

  function automatic sid_t wrap_inc(input sid_t v);
    if (int'(v) == N_STREAMS - 1) return '0;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      rr    <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_nxt      = rr;
    push        = 1'b0;
    found       = 1'b0;
    idx         = 0;
    s.tready    = '0;
    c_in.tvalid = 1'b0;
    c_in.tdata  = s.tdata[int'(grant)*DATA_BITS +: DATA_BITS];
    c_in.tkeep  = s.tkeep[int'(grant)*KB +: KB];
    c_in.tlast  = s.tlast[grant];
    case (state)
      IDLE: begin
        if (!full && |s.tvalid) begin
          // First requester at or above rr, wrapping past the top index.
          for (int i = 0; i < N_STREAMS; i++) begin
            idx = int'(rr) + i;
            if (idx >= N_STREAMS) idx = idx - N_STREAMS;
            if (!found && s.tvalid[idx]) begin
              found     = 1'b1;
              grant_nxt = sid_t'(idx);
            end
          end
          push      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        c_in.tvalid     = s.tvalid[grant];
        s.tready[grant] = c_in.tready;
        if (s.tvalid[grant] && c_in.tready && s.tlast[grant]) begin
          rr_nxt    = wrap_inc(grant);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  gzip_id_fifo #(
    .DEPTH (ID_FIFO_DEPTH),
    .W     (IW)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (grant_nxt),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

  // Return path: data is broadcast, valid/last/ready steered by the FIFO head.
  assign m.tdata = {N_STREAMS{c_out.tdata}};
  assign m.tkeep = {N_STREAMS{c_out.tkeep}};

  always_comb begin
    m.tvalid     = '0;
    m.tlast      = '0;
    c_out.tready = 1'b0;
    pop          = 1'b0;
    if (!empty) begin
      m.tvalid[head] = c_out.tvalid;
      m.tlast[head]  = c_out.tlast;
      c_out.tready   = m.tready[head];
      pop            = c_out.tvalid && m.tready[head] && c_out.tlast;
    end
  end
endmodule

// File: tb/tb_gzip_stream_arbiter.sv
// Directed bench for gzip_stream_arbiter: a per-cycle vector table plus
// hand-written sequences for round-robin, FIFO-full, backpressure and reset.
module tb_gzip_stream_arbiter;
  localparam int N  = 4;
  localparam int DB = 32;
  localparam int FD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] inflight;
  int         n_vec = 0;
  int         n_miss = 0;

  gzip_stream_arbiter_if #(.LANES(N), .DATA_BITS(DB)) s_if ();
  gzip_stream_arbiter_if #(.LANES(1), .DATA_BITS(DB)) cin_if ();
  gzip_stream_arbiter_if #(.LANES(1), .DATA_BITS(DB)) cout_if ();
  gzip_stream_arbiter_if #(.LANES(N), .DATA_BITS(DB)) m_if ();

  gzip_stream_arbiter #(
    .N_STREAMS     (N),
    .DATA_BITS     (DB),
    .ID_FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s_if),
    .c_in     (cin_if),
    .c_out    (cout_if),
    .m        (m_if),
    .inflight (inflight)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, actual running, required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] sv, sl;
    logic       cir, cov, col;
    logic [3:0] mr;
    logic [3:0] e_sr;
    logic       e_civ;
    logic [1:0] e_gid;
    logic       e_cor;
    logic [3:0] e_mv, e_ml;
    logic [4:0] e_inf;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic [3:0] sv, sl, input logic cir, cov, col,
                              input logic [3:0] mr, e_sr, input logic e_civ,
                              input logic [1:0] e_gid, input logic e_cor,
                              input logic [3:0] e_mv, e_ml, input logic [4:0] e_inf);
    vec_t v;
    v.sv = sv; v.sl = sl; v.cir = cir; v.cov = cov; v.col = col; v.mr = mr;
    v.e_sr = e_sr; v.e_civ = e_civ; v.e_gid = e_gid; v.e_cor = e_cor;
    v.e_mv = e_mv; v.e_ml = e_ml; v.e_inf = e_inf;
    return v;
  endfunction

  function automatic logic [DB-1:0] sdata(input int i);
    return 32'h5A00_0000 | (i << 8) | i;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sv, sl, input logic cir, cov, col, input logic [3:0] mr);
    s_if.tvalid    = sv;
    s_if.tlast     = sl;
    cin_if.tready  = cir;
    cout_if.tvalid = cov;
    cout_if.tlast  = col;
    m_if.tready    = mr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  int          gid[8];
  int          gcyc[8];
  int          ng;
  int          rem[N];
  int          granted;
  logic        stuck;
  logic [3:0]  hs;

  initial begin
    for (int i = 0; i < N; i++) begin
      s_if.tdata[i*DB +: DB]       = sdata(i);
      s_if.tkeep[i*DB/8 +: DB/8]   = '1;
    end
    cout_if.tdata = 32'hC0DE_0000;
    cout_if.tkeep = '1;
    // Streams 0 and 2 send 3-beat packets, echo returns them, then stream 3
    // wins from rr=3 and the wrap to stream 0 overlaps push with last pop.
    vt[0]  = mk(4'b0101, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[1]  = mk(4'b0101, 4'b0000, 1, 0, 0, 4'b1111, 4'b0001, 1, 0, 1, 4'b0000, 4'b0000, 1);
    vt[2]  = mk(4'b0101, 4'b0000, 1, 1, 0, 4'b1111, 4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 1);
    vt[3]  = mk(4'b0101, 4'b0001, 1, 1, 1, 4'b1111, 4'b0001, 1, 0, 1, 4'b0001, 4'b0001, 1);
    vt[4]  = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[5]  = mk(4'b0100, 4'b0000, 0, 0, 0, 4'b1111, 4'b0000, 1, 2, 1, 4'b0000, 4'b0000, 1);
    vt[6]  = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b1011, 4'b0100, 1, 2, 0, 4'b0100, 4'b0000, 1);
    vt[7]  = mk(4'b0100, 4'b0000, 1, 1, 1, 4'b1111, 4'b0100, 1, 2, 1, 4'b0100, 4'b0100, 1);
    vt[8]  = mk(4'b0100, 4'b0100, 1, 0, 0, 4'b1111, 4'b0100, 1, 2, 0, 4'b0000, 4'b0000, 0);
    vt[9]  = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[10] = mk(4'b1001, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[11] = mk(4'b1001, 4'b1001, 1, 0, 0, 4'b1111, 4'b1000, 1, 3, 1, 4'b0000, 4'b0000, 1);
    vt[12] = mk(4'b0001, 4'b0001, 1, 1, 1, 4'b1111, 4'b0000, 0, 0, 1, 4'b1000, 4'b1000, 1);
    vt[13] = mk(4'b0001, 4'b0001, 1, 1, 1, 4'b1111, 4'b0001, 1, 0, 1, 4'b0001, 4'b0001, 1);
    vt[14] = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);

    do_reset();
    @(negedge clk);
    chk("reset_s_tready", s_if.tready, 0);
    chk("reset_c_in_tvalid", cin_if.tvalid, 0);
    chk("reset_m_tvalid", m_if.tvalid, 0);
    chk("reset_c_out_tready", cout_if.tready, 0);
    chk("reset_inflight", inflight, 0);
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].sv, vt[i].sl, vt[i].cir, vt[i].cov, vt[i].col, vt[i].mr);
      cout_if.tdata = 32'hC0DE_0000 + i;
      @(negedge clk);
      chk($sformatf("v%0d_s_tready", i), s_if.tready, vt[i].e_sr);
      chk($sformatf("v%0d_c_in_tvalid", i), cin_if.tvalid, vt[i].e_civ);
      chk($sformatf("v%0d_c_out_tready", i), cout_if.tready, vt[i].e_cor);
      chk($sformatf("v%0d_m_tvalid", i), m_if.tvalid, vt[i].e_mv);
      chk($sformatf("v%0d_m_tlast", i), m_if.tlast, vt[i].e_ml);
      chk($sformatf("v%0d_inflight", i), inflight, vt[i].e_inf);
      if (vt[i].e_civ)
        chk($sformatf("v%0d_c_in_tdata", i), cin_if.tdata, sdata(vt[i].e_gid));
      for (int k = 0; k < N; k++)
        if (vt[i].e_mv[k])
          chk($sformatf("v%0d_m_tdata", i), m_if.tdata[k*DB +: DB], 32'hC0DE_0000 + i);
      step();
    end

    // Round robin with every stream permanently requesting 1-beat packets.
    do_reset();
    drive(4'b1111, 4'b1111, 1, 1, 1, 4'b1111);
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_if.tready != 0 && ng < 8) begin
        for (int k = 0; k < N; k++) if (s_if.tready[k]) gid[ng] = k;
        gcyc[ng] = c;
        ng++;
      end
      step();
    end
    chk("rr_grant_count", ng, 8);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("rr_order_%0d", k), gid[k], k % 4);
      if (k >= 4) chk($sformatf("rr_period_%0d", k), gcyc[k] - gcyc[k-4], 8);
    end

    // 20 packets offered with the compressor output stalled.
    do_reset();
    for (int k = 0; k < N; k++) rem[k] = 5;
    granted = 0;
    stuck = 1'b0;
    drive(4'b1111, 4'b1111, 1, 0, 0, 4'b1111);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      hs = s_if.tready & s_if.tvalid;
      for (int k = 0; k < N; k++) if (hs[k]) begin rem[k]--; granted++; end
      if (c >= 45 && s_if.tready != 0) stuck = 1'b1;
      step();
      for (int k = 0; k < N; k++) s_if.tvalid[k] = (rem[k] != 0);
    end
    chk("full_granted", granted, 16);
    chk("full_inflight", inflight, 16);
    chk("full_s_tready_held", stuck, 0);
    cout_if.tvalid = 1'b1;
    cout_if.tlast  = 1'b1;
    for (int c = 0; c < 200 && !(granted == 20 && inflight == 0); c++) begin
      @(negedge clk);
      hs = s_if.tready & s_if.tvalid;
      for (int k = 0; k < N; k++) if (hs[k]) begin rem[k]--; granted++; end
      step();
      for (int k = 0; k < N; k++) s_if.tvalid[k] = (rem[k] != 0);
    end
    chk("release_granted", granted, 20);
    chk("release_inflight", inflight, 0);

    // Head ID 1 blocked downstream; stream 2's packet must wait behind it.
    do_reset();
    drive(4'b0110, 4'b0110, 1, 0, 0, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      hs = s_if.tready & s_if.tvalid;
      step();
      s_if.tvalid = s_if.tvalid & ~hs;
    end
    chk("bp_inflight", inflight, 2);
    drive(4'b0000, 4'b0000, 1, 1, 1, 4'b1101);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_c_out_tready", cout_if.tready, 0);
      chk("bp_m_tvalid", m_if.tvalid, 4'b0010);
      step();
    end
    m_if.tready = 4'b1111;
    @(negedge clk);
    chk("bp_release_m_tlast", m_if.tlast, 4'b0010);
    chk("bp_release_c_out_tready", cout_if.tready, 1);
    step();
    @(negedge clk);
    chk("bp_next_head_m_tvalid", m_if.tvalid, 4'b0100);
    step();
    @(negedge clk);
    chk("bp_drained_inflight", inflight, 0);
    step();

    // Reset during beat 2 of a 5-beat packet from stream 3 (rr was 3).
    do_reset();
    drive(4'b0100, 4'b0100, 1, 0, 0, 4'b1111);
    step();
    step();
    drive(4'b1000, 4'b0000, 1, 0, 0, 4'b1111);
    step();
    step();
    @(negedge clk);
    chk("mid_beat2_s_tready", s_if.tready, 4'b1000);
    chk("mid_beat2_inflight", inflight, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(4'b1001, 4'b1001, 1, 1, 0, 4'b1111);
    @(negedge clk);
    chk("post_rst_s_tready", s_if.tready, 0);
    chk("post_rst_c_in_tvalid", cin_if.tvalid, 0);
    chk("post_rst_m_tvalid", m_if.tvalid, 0);
    chk("post_rst_c_out_tready", cout_if.tready, 0);
    chk("post_rst_inflight", inflight, 0);
    step();
    @(negedge clk);
    chk("post_rst_grant", s_if.tready, 4'b0001);
    chk("post_rst_c_in_tdata", cin_if.tdata, sdata(0));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
